shot_game_clock: RTL and testbench
==================================

# shot_game_clock

Game-clock stage for the ball-competition design: sits between the debounced key pulses and the main display/score logic. It keeps a BCD shot clock and a per-quarter countdown, sequences the four quarters, and emits expiry and quarter-end pulses. Its BCD digits feed the seven-segment decoder directly. Its quarter index and pulses drive the quarter LEDs and the A/B possession logic.

## Interface
Parameters:
- TICK_DIV, 12_000_000: clk cycles per game second; must be ≥ 2.
- SHOT_SEC, 24: shot-clock reload value in seconds, 1..99.
- QUARTER_SEC, 120: quarter length in seconds, 1..255.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse (debounced key) that toggles run/pause, and arms the next quarter
- shot_rst  in  1  one-cycle pulse that reloads the shot clock to SHOT_SEC
- shot_tens  out  4  shot clock tens digit, BCD
- shot_ones  out  4  shot clock ones digit, BCD
- quarter  out  2  current quarter, 0..3
- running  out  1  high in RUN
- shot_expire  out  1  one-cycle pulse when the shot clock reaches 00
- quarter_end  out  1  one-cycle pulse when the quarter time reaches 0
- game_over  out  1  level, high in OVER

## Operation
- States:
  - IDLE: after reset; clocks are loaded and halted.
  - RUN: the prescaler counts and the clocks decrement.
  - PAUSED: the clocks hold.
  - QEND: waits for the next quarter to be armed.
  - OVER: terminal state.
- Transitions:
  - IDLE to RUN on start.
  - RUN to PAUSED on start.
  - PAUSED to RUN on start.
  - RUN to QEND when the quarter time hits 0 and quarter < 3.
  - RUN to OVER when the quarter time hits 0 and quarter == 3.
  - QEND to RUN on start; the same edge increments quarter and reloads both clocks.
  - OVER is left only by reset; start is ignored in OVER.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN. tick is high when it equals TICK_DIV-1 in RUN.
  - Cleared on IDLE→RUN and on QEND→RUN.
  - Retained across PAUSED, so pausing does not lose a partial second.
- Shot clock:
  - Two-digit BCD down-counter. The ones digit wraps 0→9 with a tens borrow.
  - On tick at 01, it goes to 00 and shot_expire pulses in the same cycle.
  - At 00, later ticks leave it at 00 and give no further pulse.
- Quarter time:
  - Binary 8-bit down-counter.
  - On tick at 1, it goes to 0, quarter_end pulses, and the state leaves RUN.
  - The shot clock also reloads to SHOT_SEC on that edge.
- Simultaneous events:
  - shot_rst beats tick: the clock shows SHOT_SEC, not SHOT_SEC-1.
  - shot_rst is honoured in every state except OVER.
  - start together with tick in RUN: the tick's decrement is applied and the state goes to PAUSED.
  - If shot and quarter expiry fall on the same tick, both pulses assert in the same cycle.
- Reset mid-operation returns every register to its reset value immediately.

## Timing
- Reset values:
  - state IDLE, quarter 0, running 0, shot_expire 0, quarter_end 0, game_over 0.
  - Prescaler 0, quarter time QUARTER_SEC.
  - shot_tens/shot_ones set to the BCD of SHOT_SEC, e.g. 2/4.
- All outputs are registered.
- Inputs are sampled on the rising edge and take effect on the next cycle's outputs (1-cycle latency):
  - shot_rst → digits updated the next cycle.
  - start → running changes the next cycle.
- The first decrement after IDLE→RUN occurs TICK_DIV cycles after running rises.
- shot_expire and quarter_end are exactly one cycle wide and coincide with the cycle the new value appears.

## Configuration
- Macro SHOT_AUTO_RELOAD_EN.
- Defined: on the cycle after shot_expire, the shot clock reloads to SHOT_SEC automatically, without waiting for shot_rst. An expiry therefore shows 00 for one cycle only.
- Not defined: the shot clock holds 00 until shot_rst or a quarter reload.

## Test plan
Bench uses TICK_DIV=4, SHOT_SEC=24, QUARTER_SEC=30.
- Reset release, no stimulus for 100 cycles → digits 2/4, quarter 0, running 0, no pulses.
- start, then run 16 cycles → running 1; digits go 2/3, 2/2, 2/1, 2/0, one step every 4 cycles.
- Run to shot 01, then one tick → 0/0 and shot_expire high for exactly 1 cycle. Without the macro it holds 0/0; with the macro it shows 2/4 the next cycle.
- Pause mid-second: start at prescaler=2, hold 50 cycles, start again → no decrement during the pause; the next decrement comes 2 cycles after resume.
- shot_rst in the same cycle as a tick at 1/5 → 2/4 the next cycle, not 2/3.
- Run all four quarters with start between them → quarter_end pulses 4 times and quarter goes 0→1→2→3. After the 4th, game_over is 1, running is 0, and further starts are ignored.

Source files
------------

// File: rtl/shot_game_clock_if.sv
// Signal bundle between the game-clock stage and its neighbours: key pulses in,
// BCD shot-clock digits, quarter index and event pulses out.
interface shot_game_clock_if;
  logic       start;
  logic       shot_rst;
  logic [3:0] shot_tens;
  logic [3:0] shot_ones;
  logic [1:0] quarter;
  logic       running;
  logic       shot_expire;
  logic       quarter_end;
  logic       game_over;

  modport master (
    output start, shot_rst,
    input  shot_tens, shot_ones, quarter, running, shot_expire, quarter_end, game_over
  );

  modport slave (
    input  start, shot_rst,
    output shot_tens, shot_ones, quarter, running, shot_expire, quarter_end, game_over
  );
endinterface

// File: rtl/shot_game_clock.sv
// BCD shot clock, per-quarter countdown and four-quarter sequencer.
// Optional macro SHOT_AUTO_RELOAD_EN: reload the shot clock the cycle after it expires.
module shot_game_clock #(
  parameter int TICK_DIV    = 12_000_000,
  parameter int SHOT_SEC    = 24,
  parameter int QUARTER_SEC = 120
) (
  input  logic               clk,
  input  logic               rstn,
  shot_game_clock_if.slave   bus
);

  localparam int              PW        = $clog2(TICK_DIV);
  localparam logic [PW-1:0]   PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [3:0]      SHOT_T    = 4'(SHOT_SEC / 10);
  localparam logic [3:0]      SHOT_O    = 4'(SHOT_SEC % 10);
  localparam logic [7:0]      QSEC      = 8'(QUARTER_SEC);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_PAUSED, S_QEND, S_OVER} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [PW-1:0] r_presc;
  logic [7:0]    r_qtime;
  logic [3:0]    r_tens;
  logic [3:0]    r_ones;
  logic [1:0]    r_quarter;
  logic          r_running;
  logic          r_shot_expire;
  logic          r_quarter_end;
  logic          r_game_over;

  logic          w_tick;
  logic          w_q_hit;
  logic          w_shot_hit;
  logic          w_shot_dec;
  logic          w_arm;
  logic          w_launch;
  logic [3:0]    w_tens_next;
  logic [3:0]    w_ones_next;

  assign w_tick     = (r_state == S_RUN) && (r_presc == PRESC_MAX);
  assign w_q_hit    = w_tick && (r_qtime == 8'd1);
  assign w_shot_dec = w_tick && !((r_tens == 4'd0) && (r_ones == 4'd0));
  assign w_shot_hit = w_tick && (r_tens == 4'd0) && (r_ones == 4'd1);
  assign w_arm      = (r_state == S_QEND) && bus.start;
  assign w_launch   = ((r_state == S_IDLE) && bus.start) || w_arm;

  // Quarter expiry outranks a simultaneous start, so the pause request is dropped.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (bus.start) w_state_next = S_RUN;
      S_RUN: begin
        if (w_q_hit)        w_state_next = (r_quarter == 2'd3) ? S_OVER : S_QEND;
        else if (bus.start) w_state_next = S_PAUSED;
      end
      S_PAUSED: if (bus.start) w_state_next = S_RUN;
      S_QEND:   if (bus.start) w_state_next = S_RUN;
      S_OVER:   w_state_next = S_OVER;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // Later assignments win: any reload source overrides the tick's decrement.
  always_comb begin
    w_tens_next = r_tens;
    w_ones_next = r_ones;
    if (w_shot_dec) begin
      if (r_ones == 4'd0) begin
        w_tens_next = r_tens - 4'd1;
        w_ones_next = 4'd9;
      end else begin
        w_ones_next = r_ones - 4'd1;
      end
    end
`ifdef SHOT_AUTO_RELOAD_EN
    if (r_shot_expire) begin
      w_tens_next = SHOT_T;
      w_ones_next = SHOT_O;
    end
`endif
    if (w_q_hit || w_arm || (bus.shot_rst && (r_state != S_OVER))) begin
      w_tens_next = SHOT_T;
      w_ones_next = SHOT_O;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state       <= S_IDLE;
      r_presc       <= '0;
      r_qtime       <= QSEC;
      r_tens        <= SHOT_T;
      r_ones        <= SHOT_O;
      r_quarter     <= 2'd0;
      r_running     <= 1'b0;
      r_shot_expire <= 1'b0;
      r_quarter_end <= 1'b0;
      r_game_over   <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_tens        <= w_tens_next;
      r_ones        <= w_ones_next;
      r_running     <= (w_state_next == S_RUN);
      r_game_over   <= (w_state_next == S_OVER);
      r_shot_expire <= w_shot_hit;
      r_quarter_end <= w_q_hit;
      // The prescaler holds while paused so a partial second survives the pause.
      if (w_launch)
        r_presc <= '0;
      else if (r_state == S_RUN)
        r_presc <= w_tick ? '0 : r_presc + 1'b1;
      if (w_arm) begin
        r_qtime   <= QSEC;
        r_quarter <= r_quarter + 2'd1;
      end else if (w_tick) begin
        r_qtime <= r_qtime - 8'd1;
      end
    end
  end

  assign bus.shot_tens   = r_tens;
  assign bus.shot_ones   = r_ones;
  assign bus.quarter     = r_quarter;
  assign bus.running     = r_running;
  assign bus.shot_expire = r_shot_expire;
  assign bus.quarter_end = r_quarter_end;
  assign bus.game_over   = r_game_over;

endmodule

// File: tb/tb_shot_game_clock.sv
// Self-checking bench for shot_game_clock: directed scenarios plus random key
// pulses compared each cycle against a seconds-level game model.
module tb_shot_game_clock;
  localparam int TICK_DIV    = 4;
  localparam int SHOT_SEC    = 24;
  localparam int QUARTER_SEC = 30;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   errors = 0;
  int   checks = 0;

  shot_game_clock_if bus();

  shot_game_clock #(
    .TICK_DIV(TICK_DIV), .SHOT_SEC(SHOT_SEC), .QUARTER_SEC(QUARTER_SEC)
  ) dut (
    .clk(clk), .rstn(rstn), .bus(bus)
  );

  always #5 clk = ~clk;

  // Game model: seconds left, quarter seconds left, cycles into the current second.
  int m_shot, m_qtime, m_quarter, m_phase;
  bit m_running, m_started, m_between, m_over, m_sexp, m_qend;

  task automatic model_reset();
    m_shot = SHOT_SEC; m_qtime = QUARTER_SEC; m_quarter = 0; m_phase = 0;
    m_running = 0; m_started = 0; m_between = 0; m_over = 0; m_sexp = 0; m_qend = 0;
  endtask

  task automatic model_step(input bit st, input bit sr);
    bit tick;
    bit prev_exp;
    tick = m_running && (m_phase == TICK_DIV - 1);
    prev_exp = m_sexp;
    m_sexp = 0;
    m_qend = 0;
    if (m_over) return;
    if (tick) begin
      m_phase = 0;
      if (m_shot > 0) begin
        m_shot--;
        if (m_shot == 0) m_sexp = 1;
      end
      m_qtime--;
    end else if (m_running) begin
      m_phase++;
    end
`ifdef SHOT_AUTO_RELOAD_EN
    if (prev_exp) m_shot = SHOT_SEC;
`else
    if (prev_exp && 0) m_shot = SHOT_SEC;
`endif
    if (sr) m_shot = SHOT_SEC;
    if (tick && m_qtime == 0) begin
      m_qend = 1;
      m_shot = SHOT_SEC;
      m_running = 0;
      if (m_quarter == 3) m_over = 1;
      else m_between = 1;
    end else if (st) begin
      if (m_running) m_running = 0;
      else if (!m_started) begin
        m_started = 1; m_running = 1; m_phase = 0;
      end else if (m_between) begin
        m_between = 0; m_running = 1; m_phase = 0; m_quarter++;
        m_qtime = QUARTER_SEC; m_shot = SHOT_SEC;
      end else m_running = 1;
    end
  endtask

  function automatic logic [13:0] exp_vec();
    logic [3:0] t, o;
    t = 4'(m_shot / 10);
    o = 4'(m_shot % 10);
    return {t, o, 2'(m_quarter), m_running, m_sexp, m_qend, m_over};
  endfunction

  function automatic logic [13:0] act_vec();
    return {bus.shot_tens, bus.shot_ones, bus.quarter, bus.running,
            bus.shot_expire, bus.quarter_end, bus.game_over};
  endfunction

  task automatic step(input bit st, input bit sr);
    bus.start = st;
    bus.shot_rst = sr;
    model_step(st, sr);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.shot_rst = 1'b0;
  endtask

  task automatic do_reset();
    bus.start = 1'b0;
    bus.shot_rst = 1'b0;
    rstn = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 100; i++) begin
      step(0, 0);
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d got=%h exp=%h", i, act_vec(), exp_vec());
      end
    end
    checks++;
    if ({bus.shot_tens, bus.shot_ones} !== 8'h24) begin
      errors++;
      $display("FAIL reset_digits got=%h exp=24", {bus.shot_tens, bus.shot_ones});
    end
    $display("test_reset done: digits=%h quarter=%0d", {bus.shot_tens, bus.shot_ones}, bus.quarter);
  endtask

  task automatic test_run16();
    step(1, 0);
    checks++;
    if (bus.running !== 1'b1) begin
      errors++;
      $display("FAIL run_start running got=%b exp=1", bus.running);
    end
    for (int i = 1; i <= 16; i++) begin
      step(0, 0);
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL run16 cyc=%0d got=%h exp=%h", i, act_vec(), exp_vec());
      end
    end
    checks++;
    if ({bus.shot_tens, bus.shot_ones} !== 8'h20) begin
      errors++;
      $display("FAIL run16_digits got=%h exp=20", {bus.shot_tens, bus.shot_ones});
    end
    $display("test_run16 done: digits=%h", {bus.shot_tens, bus.shot_ones});
  endtask

  task automatic test_expire();
    int cyc;
    cyc = 0;
    while (bus.shot_expire !== 1'b1 && cyc < 200) begin
      step(0, 0);
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL expire_run cyc=%0d got=%h exp=%h", cyc, act_vec(), exp_vec());
      end
      cyc++;
    end
    checks++;
    if (cyc >= 200) begin
      errors++;
      $display("FAIL expire_timeout got=no pulse exp=pulse within 200 cycles");
    end
    checks++;
    if ({bus.shot_tens, bus.shot_ones} !== 8'h00) begin
      errors++;
      $display("FAIL expire_digits got=%h exp=00", {bus.shot_tens, bus.shot_ones});
    end
    step(0, 0);
    checks++;
    if (bus.shot_expire !== 1'b0) begin
      errors++;
      $display("FAIL expire_width got=%b exp=0", bus.shot_expire);
    end
    checks++;
`ifdef SHOT_AUTO_RELOAD_EN
    if ({bus.shot_tens, bus.shot_ones} !== 8'h24) begin
      errors++;
      $display("FAIL expire_after got=%h exp=24", {bus.shot_tens, bus.shot_ones});
    end
`else
    if ({bus.shot_tens, bus.shot_ones} !== 8'h00) begin
      errors++;
      $display("FAIL expire_after got=%h exp=00", {bus.shot_tens, bus.shot_ones});
    end
`endif
    for (int i = 0; i < 8; i++) begin
      step(0, 0);
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL expire_hold cyc=%0d got=%h exp=%h", i, act_vec(), exp_vec());
      end
    end
    $display("test_expire done: pulse after %0d cycles, digits=%h", cyc, {bus.shot_tens, bus.shot_ones});
  endtask

  task automatic test_pause();
    logic [7:0] d0;
    int v;
    step(0, 1);
    checks++;
    if ({bus.shot_tens, bus.shot_ones} !== 8'h24) begin
      errors++;
      $display("FAIL pause_reload got=%h exp=24", {bus.shot_tens, bus.shot_ones});
    end
    for (int i = 0; i < 10 && m_phase != 1; i++) step(0, 0);
    step(1, 0);
    checks++;
    if (bus.running !== 1'b0) begin
      errors++;
      $display("FAIL pause_enter running got=%b exp=0", bus.running);
    end
    d0 = {bus.shot_tens, bus.shot_ones};
    for (int i = 0; i < 50; i++) begin
      step(0, 0);
      checks++;
      if (act_vec() !== exp_vec() || {bus.shot_tens, bus.shot_ones} !== d0) begin
        errors++;
        $display("FAIL pause_hold cyc=%0d got=%h exp=%h", i, act_vec(), exp_vec());
      end
    end
    step(1, 0);
    checks++;
    if (bus.running !== 1'b1 || {bus.shot_tens, bus.shot_ones} !== d0) begin
      errors++;
      $display("FAIL pause_resume got=%b/%h exp=1/%h", bus.running, {bus.shot_tens, bus.shot_ones}, d0);
    end
    step(0, 0);
    checks++;
    if ({bus.shot_tens, bus.shot_ones} !== d0) begin
      errors++;
      $display("FAIL pause_resume1 got=%h exp=%h", {bus.shot_tens, bus.shot_ones}, d0);
    end
    step(0, 0);
    v = int'(d0[7:4]) * 10 + int'(d0[3:0]) - 1;
    checks++;
    if ({bus.shot_tens, bus.shot_ones} !== {4'(v / 10), 4'(v % 10)}) begin
      errors++;
      $display("FAIL pause_resume2 got=%h exp=%0d", {bus.shot_tens, bus.shot_ones}, v);
    end
    $display("test_pause done: held %h, now %h", d0, {bus.shot_tens, bus.shot_ones});
  endtask

  task automatic test_shot_rst_tick();
    bit done;
    done = 0;
    for (int cyc = 0; cyc < 1000 && !done; cyc++) begin
      if (m_running && m_phase == TICK_DIV - 1 && m_shot == 15) begin
        step(0, 1);
        done = 1;
        checks++;
        if ({bus.shot_tens, bus.shot_ones} !== 8'h24 || act_vec() !== exp_vec()) begin
          errors++;
          $display("FAIL shotrst_tick got=%h exp=%h (digits 24)", act_vec(), exp_vec());
        end
      end else begin
        step(!m_running && !m_over, 0);
        checks++;
        if (act_vec() !== exp_vec()) begin
          errors++;
          $display("FAIL shotrst_run cyc=%0d got=%h exp=%h", cyc, act_vec(), exp_vec());
        end
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL shotrst_timeout got=never at 15 exp=reach 15");
    end
    $display("test_shot_rst_tick done: digits=%h", {bus.shot_tens, bus.shot_ones});
  endtask

  task automatic test_midreset();
    if (!m_running) step(1, 0);
    for (int i = 0; i < 10; i++) step(0, 0);
    #2;
    rstn = 1'b0;
    model_reset();
    #1;
    checks++;
    if (act_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL midreset_async got=%h exp=%h", act_vec(), exp_vec());
    end
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    $display("test_midreset done: vec=%h", act_vec());
  endtask

  task automatic test_quarters();
    int pulses;
    int cyc;
    do_reset();
    pulses = 0;
    cyc = 0;
    while (!m_over && cyc < 2000) begin
      step(!m_running && !m_over, 0);
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL quarters_run cyc=%0d got=%h exp=%h", cyc, act_vec(), exp_vec());
      end
      if (bus.quarter_end === 1'b1) begin
        pulses++;
        checks++;
        if (bus.quarter !== 2'(pulses - 1)) begin
          errors++;
          $display("FAIL quarter_index got=%0d exp=%0d", bus.quarter, pulses - 1);
        end
      end
      cyc++;
    end
    checks++;
    if (pulses != 4) begin
      errors++;
      $display("FAIL quarter_pulses got=%0d exp=4", pulses);
    end
    checks++;
    if (bus.game_over !== 1'b1 || bus.running !== 1'b0) begin
      errors++;
      $display("FAIL game_over got=over%b run%b exp=over1 run0", bus.game_over, bus.running);
    end
    for (int i = 0; i < 5; i++) begin
      step(1, 0);
      step(0, 1);
      checks++;
      if (act_vec() !== exp_vec() || bus.quarter !== 2'd3 || bus.running !== 1'b0) begin
        errors++;
        $display("FAIL over_ignore i=%0d got=%h exp=%h", i, act_vec(), exp_vec());
      end
    end
    $display("test_quarters done: pulses=%0d quarter=%0d over=%b", pulses, bus.quarter, bus.game_over);
  endtask

  task automatic test_random();
    bit st, sr;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (m_over) do_reset();
      st = ($urandom_range(0, (m_between || !m_started) ? 3 : 39) == 0);
      sr = ($urandom_range(0, 29) == 0);
      step(st, sr);
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random cyc=%0d st=%b sr=%b got=%h exp=%h", i, st, sr, act_vec(), exp_vec());
      end
    end
    $display("test_random done: quarter=%0d digits=%h", bus.quarter, {bus.shot_tens, bus.shot_ones});
  endtask

  initial begin
    bus.start = 1'b0;
    bus.shot_rst = 1'b0;
    model_reset();
    test_reset();
    test_run16();
    test_expire();
    test_pause();
    test_shot_rst_tick();
    test_midreset();
    test_quarters();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
